piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out stage downstream of the 8-bit P4 holding register.
//  - Captures the register word q (driven on data_in) on a start request.
//  - Shifts the word out one bit at a time on serial_out, each bit held for CLKS_PER_BIT clocks.
//  - Reports progress with busy and a one-cycle done pulse.
// PARAMETERS
//  WIDTH         8  word width in bits (>=2)
//  CLKS_PER_BIT  4  clocks each bit is held on serial_out (>=1)
//  MSB_FIRST     1  1: shift out bit WIDTH-1 first; 0: shift out bit 0 first
//  IDLE_LEVEL    0  serial_out level when not shifting
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-low reset (0 = reset)
//  start       in   1      request; sampled only in IDLE
//  data_in     in   WIDTH  parallel word, from P4 q
//  serial_out  out  1      serial data, registered
//  bit_valid   out  1      high while serial_out carries a data bit
//  busy        out  1      high from the cycle after start is accepted until the last bit ends
//  done        out  1      one-cycle pulse after the last bit
// BEHAVIOUR
//  - Reset (async, rst=0): state=IDLE, shreg=0, counters=0,
//    serial_out=IDLE_LEVEL, bit_valid=0, busy=0, done=0.
//    Reset mid-shift aborts the word; no done pulse is produced.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE:
//    - Outputs idle.
//    - start=1 at edge k: shreg<=data_in, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
//    - First bit is visible on serial_out after edge k (latency 1 clk).
//  - SHIFT:
//    - serial_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]; bit_valid=1, busy=1.
//    - div_cnt counts 0..CLKS_PER_BIT-1. On terminal count:
//      - shreg shifts by one (toward the output end, zero fill);
//      - bit_cnt increments;
//      - after bit WIDTH-1 completes, state<=DONE.
//    - Total SHIFT duration is exactly WIDTH*CLKS_PER_BIT cycles.
//  - DONE (1 cycle): done=1, busy=0, bit_valid=0, serial_out=IDLE_LEVEL; then IDLE.
//    start in this cycle is ignored.
//  - start while busy or in DONE: ignored; the word in flight is unaffected.
//    data_in changes after capture have no effect.
//  - CLKS_PER_BIT=1: a new bit appears every clock, with no gaps.
//  - Widths: bit_cnt is $clog2(WIDTH) bits; div_cnt is max(1,$clog2(CLKS_PER_BIT)) bits.
//    Neither counter wraps past its terminal value.
//  - All outputs are registered; there are no combinational paths from inputs to outputs.
// STRUCTURE
//  - serializer_defs.vh (shared include):
//    - state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
//    - default width constant WORD_W=8, shared with P4 and its bench.
//  - Sub-module bit_tick_gen: div_cnt plus terminal-count tick.
//    - Ports: clk, rst, en, tick.
//    - Parameter CLKS_PER_BIT.
//  - Top level holds the FSM, shreg and bit_cnt.
// TESTING (semiperiod 20 ns, WIDTH=8, CLKS_PER_BIT=4)
//  1. Reset: hold rst=0 for 4 semiperiods with start=1 -> serial_out=0, busy=0, done=0 throughout.
//  2. MSB-first: data_in=167 (8'hA7), 1-cycle start ->
//     - serial_out = 1,0,1,0,0,1,1,1, each held 4 clks;
//     - busy high 32 clks, then done pulses once.
//  3. LSB-first (MSB_FIRST=0): data_in=167 -> serial_out = 1,1,1,0,0,1,0,1.
//  4. Start while busy: start pulse during bit 3 with data_in=8'h00 -> original 8'hA7 stream completes unchanged;
//     exactly one done pulse.
//  5. Reset mid-shift: rst=0 during bit 5 -> outputs clear immediately (async), no done;
//     a new start after release sends a full word.
//  6. CLKS_PER_BIT=1, data_in=8'hFF then 8'h00 back-to-back (start in the first IDLE cycle after done) ->
//     - 8 consecutive 1s;
//     - 2 idle clks (DONE, IDLE);
//     - 8 consecutive 0s.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out stage behind the P4 holding register.
package piso_serializer_pkg;

    // Default word width, shared with P4 and its bench.
    localparam int unsigned WordW = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Counter width that still works when the count range is a single value.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_tick_gen.sv
// Bit-period divider: counts 0..ClksPerBit-1 while enabled and flags the terminal count.
module piso_serializer_bit_tick_gen
    import piso_serializer_pkg::*;
#(
    parameter int unsigned ClksPerBit = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = cnt_width(ClksPerBit);
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    assign tick_o = en_i && (div_cnt_q == CntMax);

    // Held at zero while disabled so every word starts on a fresh bit period.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!en_i || tick_o) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Serialises one captured word per start request; all outputs come straight from flops.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned Width      = WordW,
    parameter int unsigned ClksPerBit = 4,
    parameter bit          MsbFirst   = 1'b1,
    parameter bit          IdleLevel  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] data_i,
    output logic             serial_o,
    output logic             bit_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned BitW = cnt_width(Width);
    localparam logic [BitW-1:0] BitMax = BitW'(Width - 1);

    state_e           state_q;
    logic [Width-1:0] shreg_q;
    logic [BitW-1:0]  bit_cnt_q;
    logic             serial_q;
    logic             bit_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             bit_tick;
    logic [Width-1:0] shreg_shifted;
    logic             first_bit;
    logic             next_bit;

    piso_serializer_bit_tick_gen #(
        .ClksPerBit(ClksPerBit)
    ) u_bit_tick_gen (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (state_q == StShift),
        .tick_o(bit_tick)
    );

    // serial_q is loaded with the bit that will sit at the output end after each update.
    always_comb begin
        if (MsbFirst) begin
            shreg_shifted = {shreg_q[Width-2:0], 1'b0};
            first_bit     = data_i[Width-1];
            next_bit      = shreg_q[Width-2];
        end else begin
            shreg_shifted = {1'b0, shreg_q[Width-1:1]};
            first_bit     = data_i[0];
            next_bit      = shreg_q[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            serial_q    <= IdleLevel;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q     <= StShift;
                        shreg_q     <= data_i;
                        bit_cnt_q   <= '0;
                        serial_q    <= first_bit;
                        bit_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StShift: begin
                    if (bit_tick) begin
                        shreg_q <= shreg_shifted;
                        if (bit_cnt_q == BitMax) begin
                            state_q     <= StDone;
                            serial_q    <= IdleLevel;
                            bit_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                            serial_q  <= next_bit;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    serial_q    <= IdleLevel;
                    bit_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign serial_o    = serial_q;
    assign bit_valid_o = bit_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus, plus a 1-clk/bit one.
module tb_piso_serializer;
    import piso_serializer_pkg::*;

    localparam int unsigned W   = WordW;
    localparam int unsigned Cpb = 4;

    typedef struct {
        logic [7:0] data;
        logic [7:0] ms;   // expected MSB-first stream, first bit leftmost
        logic [7:0] ls;   // expected LSB-first stream, first bit leftmost
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data;
    logic         start_f;
    logic [W-1:0] data_f;

    logic ser_m, val_m, busy_m, done_m;
    logic ser_l, val_l, busy_l, done_l;
    logic ser_f, val_f, busy_f, done_f;

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cnt_l = 0;
    bit q_m[$];
    bit q_l[$];
    vec_t vecs[5];

    always #20 clk = ~clk;

    piso_serializer #(.Width(W), .ClksPerBit(Cpb), .MsbFirst(1'b1), .IdleLevel(1'b0)) u_msb (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data),
        .serial_o(ser_m), .bit_valid_o(val_m), .busy_o(busy_m), .done_o(done_m)
    );

    piso_serializer #(.Width(W), .ClksPerBit(Cpb), .MsbFirst(1'b0), .IdleLevel(1'b0)) u_lsb (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data),
        .serial_o(ser_l), .bit_valid_o(val_l), .busy_o(busy_l), .done_o(done_l)
    );

    piso_serializer #(.Width(W), .ClksPerBit(1), .MsbFirst(1'b1), .IdleLevel(1'b0)) u_fast (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_f), .data_i(data_f),
        .serial_o(ser_f), .bit_valid_o(val_f), .busy_o(busy_f), .done_o(done_f)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every cycle with bit_valid pops one expected bit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (val_m) begin
                check("msb_bit_pending", 32'(q_m.size() != 0), 1);
                if (q_m.size() != 0) check("msb_bit", ser_m, q_m.pop_front());
            end else begin
                check("msb_idle_level", ser_m, 0);
            end
            if (val_l) begin
                check("lsb_bit_pending", 32'(q_l.size() != 0), 1);
                if (q_l.size() != 0) check("lsb_bit", ser_l, q_l.pop_front());
            end else begin
                check("lsb_idle_level", ser_l, 0);
            end
            if (busy_m) busy_cnt++;
            if (done_m) done_cnt++;
            if (done_l) done_cnt_l++;
        end
    end

    task automatic push_word(input logic [7:0] ms, input logic [7:0] ls);
        for (int i = 7; i >= 0; i--) begin
            for (int c = 0; c < int'(Cpb); c++) begin
                q_m.push_back(ms[i]);
                q_l.push_back(ls[i]);
            end
        end
    endtask

    task automatic run_word(input vec_t v, input bit busy_start);
        int t;
        busy_cnt   = 0;
        done_cnt   = 0;
        done_cnt_l = 0;
        @(negedge clk);
        data  = v.data;
        start = 1'b1;
        push_word(v.ms, v.ls);
        @(negedge clk);
        start = 1'b0;
        data  = ~v.data;
        check("busy_after_start", busy_m, 1);
        if (busy_start) begin
            repeat (12) @(negedge clk);
            data  = '0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (!done_m && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done_m, 1);
        repeat (3) @(negedge clk);
        check("busy_cycles", busy_cnt, 32);
        check("done_pulses", done_cnt, 1);
        check("done_pulses_lsb", done_cnt_l, 1);
        check("queue_drained", q_m.size() + q_l.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vecs[0] = '{data: 8'hA7, ms: 8'b10100111, ls: 8'b11100101};
        vecs[1] = '{data: 8'h3C, ms: 8'b00111100, ls: 8'b00111100};
        vecs[2] = '{data: 8'h01, ms: 8'b00000001, ls: 8'b10000000};
        vecs[3] = '{data: 8'hC4, ms: 8'b11000100, ls: 8'b00100011};
        vecs[4] = '{data: 8'hFF, ms: 8'b11111111, ls: 8'b11111111};

        // Reset held with start asserted: outputs must stay idle.
        rst_n   = 1'b0;
        start   = 1'b1;
        data    = 8'hA7;
        start_f = 1'b0;
        data_f  = '0;
        for (int i = 0; i < 4; i++) begin
            @(clk);
            #1;
            check("rst_serial", ser_m, 0);
            check("rst_busy", busy_m, 0);
            check("rst_done", done_m, 0);
            check("rst_valid", val_m, 0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_word(vecs[i], 1'b0);

        // Start during bit 3 must not disturb the word in flight.
        run_word(vecs[0], 1'b1);

        // Asynchronous reset during bit 5 aborts the word with no done pulse.
        done_cnt = 0;
        @(negedge clk);
        data  = 8'hA7;
        start = 1'b1;
        push_word(vecs[0].ms, vecs[0].ls);
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        check("abort_serial", ser_m, 0);
        check("abort_valid", val_m, 0);
        check("abort_busy", busy_m, 0);
        check("abort_busy_lsb", busy_l, 0);
        check("abort_done", done_m, 0);
        q_m.delete();
        q_l.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        run_word(vecs[0], 1'b0);

        // One clock per bit, second word started in the first IDLE cycle after done.
        @(negedge clk);
        data_f  = 8'hFF;
        start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
        for (int k = 0; k < 18; k++) begin
            check("fast_valid", val_f, 32'((k < 8) || (k >= 10)));
            check("fast_busy", busy_f, 32'((k < 8) || (k >= 10)));
            check("fast_serial", ser_f, 32'(k < 8));
            check("fast_done", done_f, 32'(k == 8));
            if (k == 9) begin
                data_f  = 8'h00;
                start_f = 1'b1;
            end
            if (k == 10) start_f = 1'b0;
            if (k < 17) @(negedge clk);
        end
        t = 0;
        while (!done_f && t < 4) begin
            @(negedge clk);
            t++;
        end
        check("fast_second_done", done_f, 1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
